unified_mem_arbiter: RTL

Parametrised single-port unified instruction/data memory with a two-client arbiter, for the pipelined CPU wrapper. It replaces direct memory array access with a request/grant handshake. It adds a configurable read latency and starvation-bounded fairness between fetch and data (LDD/LDI/STD/STI/stack) accesses. One array access per cycle; the loser sees gnt low and must stall.

---
 rtl/unified_mem_arbiter_if.sv | 59 +++++
 rtl/unified_mem_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// unified_mem_arbiter_if
// Request/grant bus between the pipelined CPU wrapper and the unified
// instruction/data memory arbiter. One fetch read channel, one data
// load/store channel.
//
// Parameters:
//   DATA_W  word width in bits
//   ADDR_W  address width
//
// Signals:
//   if_req / if_addr            fetch read request and address (CPU -> mem)
//   if_gnt                      fetch request accepted this cycle (mem -> CPU)
//   if_rvalid / if_rdata        fetch read response (mem -> CPU)
//   d_req / d_we / d_addr /
//   d_wdata                     data load/store request (CPU -> mem)
//   d_gnt                       data request accepted this cycle (mem -> CPU)
//   d_rvalid / d_rdata          load response (mem -> CPU)
//
// Modports:
//   master  CPU side (drives requests, receives grants and responses)
//   slave   memory/arbiter side
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface unified_mem_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata
  );

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata
  );

endinterface

// File: rtl/unified_mem_arbiter.sv
// ---------------------------------------------------------------------------
// unified_mem_arbiter
// Single-port unified instruction/data memory shared by a fetch client and a
// data (load/store/stack) client. At most one array access happens per cycle;
// the losing client sees its gnt low and has to stall and retry.
//
// Parameters:
//   DATA_W      word width in bits (default 8)
//   ADDR_W      address width, array depth = 2**ADDR_W (default 8)
//   RD_LAT      cycles from grant cycle to rvalid, 1..4 (default 1)
//   STARVE_MAX  consecutive conflict cycles data may win before fetch is
//               forced through; 0 means data always wins (default 3)
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset (memory contents are kept)
//   bus   unified_mem_arbiter_if.slave: fetch and data request/grant/response
//
// Optional feature (macro MEM_ARB_PERF_CNT_EN):
//   perf_if_gnt, perf_d_gnt, perf_conflict  16-bit saturating counters of
//   fetch grants, data grants and conflict cycles. Absent when the macro is
//   not defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module unified_mem_arbiter #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 8,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  unified_mem_arbiter_if.slave bus
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [15:0]          perf_if_gnt,
  output logic [15:0]          perf_d_gnt,
  output logic [15:0]          perf_conflict
`endif
);

  localparam int DEPTH    = 1 << ADDR_W;
  localparam int CNT_RAW  = $clog2(STARVE_MAX + 1);
  localparam int CNT_W    = (CNT_RAW < 1) ? 1 : CNT_RAW;
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  // Reject unsupported read latencies while elaborating.
  generate
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
      $error("unified_mem_arbiter: RD_LAT must be in 1..4");
    end
  endgenerate

  logic [DATA_W-1:0] mem [DEPTH];

  logic [CNT_W-1:0]  starve_cnt;
  logic              conflict;
  logic              force_if;
  logic              if_gnt_c;
  logic              d_gnt_c;
  logic              wr_en;
  logic              rd_gnt;
  logic              rd_is_d;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  // What arrives at the output stage on the next edge.
  logic              fwd_valid;
  logic              fwd_is_d;
  logic [DATA_W-1:0] fwd_data;

  // Single-winner arbitration. Data normally wins a conflict because a stalled
  // load/store blocks the pipeline further down than a stalled fetch; the
  // starvation counter forces fetch through after STARVE_MAX data wins in a
  // row so instruction supply cannot be locked out indefinitely.
  always_comb begin
    conflict = bus.if_req && bus.d_req;
    force_if = (STARVE_MAX != 0) && (starve_cnt == STARVE_LIM);
    if_gnt_c = 1'b0;
    d_gnt_c  = 1'b0;
    if (!rst) begin
      if (conflict) begin
        if (force_if) begin
          if_gnt_c = 1'b1;
        end else begin
          d_gnt_c = 1'b1;
        end
      end else begin
        if_gnt_c = bus.if_req;
        d_gnt_c  = bus.d_req;
      end
    end
  end

  assign bus.if_gnt = if_gnt_c;
  assign bus.d_gnt  = d_gnt_c;

  // Decode the single array access that happens this cycle.
  always_comb begin
    wr_en   = d_gnt_c && bus.d_we;
    rd_gnt  = if_gnt_c || (d_gnt_c && !bus.d_we);
    rd_is_d = d_gnt_c;
    rd_addr = if_gnt_c ? bus.if_addr : bus.d_addr;
    rd_data = mem[rd_addr];
  end

  // Starvation counter: counts consecutive conflicts won by data, saturating
  // at the limit; any fetch win or conflict-free cycle starts over.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (conflict && d_gnt_c) begin
      if (starve_cnt != STARVE_LIM) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end else begin
      starve_cnt <= '0;
    end
  end

  // Memory array is deliberately not reset so program/data images survive a
  // CPU reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[bus.d_addr] <= bus.d_wdata;
    end
  end

  // Read pipeline. The array is read at the grant edge, so a read granted
  // before a store always carries the old word no matter when it is
  // delivered. RD_LAT-1 internal stages feed the registered output stage.
  generate
    if (RD_LAT <= 1) begin : g_direct
      assign fwd_valid = rd_gnt;
      assign fwd_is_d  = rd_is_d;
      assign fwd_data  = rd_data;
    end else begin : g_pipe
      logic [RD_LAT-2:0] pv;
      logic [RD_LAT-2:0] p_is_d;
      logic [DATA_W-1:0] pdat [RD_LAT-1];

      // Shift valid, source tag and data together so responses stay in
      // grant order; a reset empties every stage, dropping in-flight reads.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pv     <= '0;
          p_is_d <= '0;
          pdat   <= '{default: '0};
        end else begin
          pv[0]     <= rd_gnt;
          p_is_d[0] <= rd_is_d;
          pdat[0]   <= rd_data;
          for (int i = 1; i < RD_LAT - 1; i++) begin
            pv[i]     <= pv[i-1];
            p_is_d[i] <= p_is_d[i-1];
            pdat[i]   <= pdat[i-1];
          end
        end
      end

      assign fwd_valid = pv[RD_LAT-2];
      assign fwd_is_d  = p_is_d[RD_LAT-2];
      assign fwd_data  = pdat[RD_LAT-2];
    end
  endgenerate

  // Output stage: route the response by its source tag. Each rdata only
  // updates when its own response arrives so the CPU can consume it late.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.if_rvalid <= 1'b0;
      bus.d_rvalid  <= 1'b0;
      bus.if_rdata  <= '0;
      bus.d_rdata   <= '0;
    end else begin
      bus.if_rvalid <= fwd_valid && !fwd_is_d;
      bus.d_rvalid  <= fwd_valid && fwd_is_d;
      if (fwd_valid && !fwd_is_d) begin
        bus.if_rdata <= fwd_data;
      end
      if (fwd_valid && fwd_is_d) begin
        bus.d_rdata <= fwd_data;
      end
    end
  end

`ifdef MEM_ARB_PERF_CNT_EN
  // Performance counters saturate instead of wrapping so a long run never
  // reports a misleadingly small number.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_if_gnt   <= '0;
      perf_d_gnt    <= '0;
      perf_conflict <= '0;
    end else begin
      if (if_gnt_c && perf_if_gnt != 16'hFFFF) begin
        perf_if_gnt <= perf_if_gnt + 16'd1;
      end
      if (d_gnt_c && perf_d_gnt != 16'hFFFF) begin
        perf_d_gnt <= perf_d_gnt + 16'd1;
      end
      if (conflict && perf_conflict != 16'hFFFF) begin
        perf_conflict <= perf_conflict + 16'd1;
      end
    end
  end
`endif

endmodule
